// File: rtl/choice_predictor.sv
// choice_predictor
// Tournament meta-predictor. A table of saturating counters, indexed by global
// branch history, picks the global predictor (counter MSB set) or the local
// predictor for the current lookup. Training is delayed: the lp/gp predictions
// and the index are carried down an UPDATE_DELAY-deep chain. The chain's tail
// meets actually_taken, and the counter at that index is then nudged toward
// whichever predictor was right.
//
// Optional build macro: CHOICE_PRED_STATS_EN. It adds the stat_gp_wins and
// stat_lp_wins counters. These count the validated updates where only gp, or
// only lp, was correct.

module choice_predictor #(
    parameter int HIST_W       = 12,
    parameter int CTR_W        = 3,
    parameter int UPDATE_DELAY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [HIST_W-1:0] global_history,
    input  logic              lp_prediction,
    input  logic              gp_prediction,
    input  logic              actually_taken,
`ifdef CHOICE_PRED_STATS_EN
    output logic [31:0]       stat_gp_wins,
    output logic [31:0]       stat_lp_wins,
`endif
    output logic              choice_prediction
);

    localparam int              DEPTH    = 1 << HIST_W;
    localparam logic [CTR_W-1:0] CTR_INIT = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_ZERO = {CTR_W{1'b0}};
    localparam logic [CTR_W-1:0] CTR_ONE  = {{(CTR_W-1){1'b0}}, 1'b1};

    logic [CTR_W-1:0]  r_table      [DEPTH];
    logic              r_pipe_valid [UPDATE_DELAY];
    logic [HIST_W-1:0] r_pipe_idx   [UPDATE_DELAY];
    logic              r_pipe_lp    [UPDATE_DELAY];
    logic              r_pipe_gp    [UPDATE_DELAY];

    logic              w_tail_valid;
    logic [HIST_W-1:0] w_tail_idx;
    logic              w_gp_ok;
    logic              w_lp_ok;
    logic              w_gp_win;
    logic              w_lp_win;
    logic [CTR_W-1:0]  w_ctr_cur;
    logic [CTR_W-1:0]  w_ctr_next;

    // Zero-latency lookup. A same-cycle write to this index lands on the edge,
    // so the lookup always sees the pre-update value.
    assign choice_prediction = r_table[global_history][CTR_W-1];

    assign w_tail_valid = r_pipe_valid[UPDATE_DELAY-1];
    assign w_tail_idx   = r_pipe_idx[UPDATE_DELAY-1];
    assign w_gp_ok      = (r_pipe_gp[UPDATE_DELAY-1] == actually_taken);
    assign w_lp_ok      = (r_pipe_lp[UPDATE_DELAY-1] == actually_taken);
    assign w_gp_win     = w_tail_valid &&  w_gp_ok && !w_lp_ok;
    assign w_lp_win     = w_tail_valid &&  w_lp_ok && !w_gp_ok;
    assign w_ctr_cur    = r_table[w_tail_idx];

    // Saturating step of the counter being trained this cycle.
    always_comb begin
        // NOTE: default first, so that every path assigns w_ctr_next and no latch is inferred.
        w_ctr_next = w_ctr_cur;
        if (w_gp_win && (w_ctr_cur != CTR_MAX)) begin
            w_ctr_next = w_ctr_cur + CTR_ONE;
        end else if (w_lp_win && (w_ctr_cur != CTR_ZERO)) begin
            w_ctr_next = w_ctr_cur - CTR_ONE;
        end
    end

    // Lookup history chain: a new entry is pushed each cycle, and the tail is the entry being resolved.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < UPDATE_DELAY; i++) begin
                r_pipe_valid[i] <= 1'b0;
                r_pipe_idx[i]   <= '0;
                r_pipe_lp[i]    <= 1'b0;
                r_pipe_gp[i]    <= 1'b0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage shift from its pre-edge neighbour.
            r_pipe_valid[0] <= 1'b1;
            r_pipe_idx[0]   <= global_history;
            r_pipe_lp[0]    <= lp_prediction;
            r_pipe_gp[0]    <= gp_prediction;
            for (int i = 1; i < UPDATE_DELAY; i++) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
                r_pipe_idx[i]   <= r_pipe_idx[i-1];
                r_pipe_lp[i]    <= r_pipe_lp[i-1];
                r_pipe_gp[i]    <= r_pipe_gp[i-1];
            end
        end
    end

    // Counter table: reinitialised to weakly-global on reset, trained from the tail entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the table is built from flops, not RAM, because every entry must
            // return to weakly-global immediately when reset is asserted.
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= CTR_INIT;
            end
        end else if (w_gp_win || w_lp_win) begin
            r_table[w_tail_idx] <= w_ctr_next;
        end
    end

`ifdef CHOICE_PRED_STATS_EN
    logic [31:0] r_gp_wins;
    logic [31:0] r_lp_wins;

    // Win counters. They wrap freely at 2**32.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_gp_wins <= '0;
            r_lp_wins <= '0;
        end else begin
            if (w_gp_win) r_gp_wins <= r_gp_wins + 32'd1;
            if (w_lp_win) r_lp_wins <= r_lp_wins + 32'd1;
        end
    end

    assign stat_gp_wins = r_gp_wins;
    assign stat_lp_wins = r_lp_wins;
`endif

endmodule

// File: tb/tb_choice_predictor.sv
// Testbench for choice_predictor. A behavioural model keeps one integer
// counter per index and a queue of unresolved lookups. The lookup that is
// UPDATE_DELAY cycles old is paired with this cycle's actually_taken.

module tb_choice_predictor;

    localparam int HIST_W = 12;
    localparam int CTR_W  = 3;
    localparam int D      = 2;
    localparam int DEPTH  = 1 << HIST_W;

    logic              clock;
    logic              reset;
    logic [HIST_W-1:0] global_history;
    logic              lp_prediction;
    logic              gp_prediction;
    logic              actually_taken;
    logic              choice_prediction;
`ifdef CHOICE_PRED_STATS_EN
    logic [31:0]       stat_gp_wins;
    logic [31:0]       stat_lp_wins;
`endif

    choice_predictor #(.HIST_W(HIST_W), .CTR_W(CTR_W), .UPDATE_DELAY(D)) dut (
        .clock             (clock),
        .reset             (reset),
        .global_history    (global_history),
        .lp_prediction     (lp_prediction),
        .gp_prediction     (gp_prediction),
        .actually_taken    (actually_taken),
`ifdef CHOICE_PRED_STATS_EN
        .stat_gp_wins      (stat_gp_wins),
        .stat_lp_wins      (stat_lp_wins),
`endif
        .choice_prediction (choice_prediction)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int idx;
        bit lp;
        bit gp;
    } lookup_t;

    int      model [DEPTH];
    lookup_t pend  [$];
    int      checks   = 0;
    int      failures = 0;
    int      gp_wins  = 0;
    int      lp_wins  = 0;

    task automatic check(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model[i] = 1 << (CTR_W - 1);
        pend.delete();
    endtask

    // One cycle: drive the inputs, check the lookup against the model's
    // pre-update counter, then resolve the oldest lookup and queue this one.
    // The task is entered and left at a falling edge.
    task automatic step(input int hist, input bit lp, input bit gp, input bit at, input string tag);
        lookup_t e;
        global_history = hist[HIST_W-1:0];
        lp_prediction  = lp;
        gp_prediction  = gp;
        actually_taken = at;
        #1;
        check(tag, choice_prediction, (model[hist] >= (1 << (CTR_W - 1))) ? 1'b1 : 1'b0);
        if (pend.size() == D) begin
            e = pend.pop_front();
            if ((e.gp == at) && (e.lp != at)) begin
                gp_wins++;
                if (model[e.idx] < (1 << CTR_W) - 1) model[e.idx] = model[e.idx] + 1;
            end else if ((e.lp == at) && (e.gp != at)) begin
                lp_wins++;
                if (model[e.idx] > 0) model[e.idx] = model[e.idx] - 1;
            end
        end
        e.idx = hist;
        e.lp  = lp;
        e.gp  = gp;
        pend.push_back(e);
        @(negedge clock);
    endtask

    // Assert reset for one cycle. The lookup of probe_hist must read 1 while reset is held.
    task automatic pulse_reset(input int probe_hist, input string tag);
        global_history = probe_hist[HIST_W-1:0];
        reset = 1'b0;
        #1;
        check(tag, choice_prediction, 1'b1);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        global_history = '0;
        lp_prediction  = 1'b0;
        gp_prediction  = 1'b0;
        actually_taken = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        global_history = HIST_W'(5);
        #1;
        check("in_reset_reads_1", choice_prediction, 1'b1);
        @(negedge clock);
        reset = 1'b1;

        // 1: hold index 5, toggle the outcome. The first D cycles must not train.
        for (int i = 0; i < 4; i++) step(5, 1'b0, 1'b1, i[0], "t1_idx5_startup");

        // 2: gp right, lp wrong on index 20. The counter climbs to 7 and saturates.
        for (int i = 0; i < 6; i++) step(20, 1'b0, 1'b1, 1'b1, "t2_gp_wins");

        // 3: lp right on index 20. The counter falls to 0, and the MSB drops at 3.
        for (int i = 0; i < 10; i++) step(20, 1'b0, 1'b1, 1'b0, "t3_lp_wins");

        // 4: gp == lp on index 1, first both right and then both wrong. No change.
        for (int i = 0; i < 3; i++) step(1, 1'b1, 1'b1, 1'b1, "t4_both_right");
        for (int i = 0; i < 3; i++) step(1, 1'b0, 1'b0, 1'b1, "t4_both_wrong");
        for (int i = 0; i < D; i++) step(1, 1'b0, 1'b0, 1'b0, "t4_flush");

        // 5: index 20 holds 0, and gp-winning updates to 20 are in flight. Then reset.
        step(20, 1'b0, 1'b1, 1'b1, "t5_pending_a");
        step(20, 1'b0, 1'b1, 1'b1, "t5_pending_b");
        pulse_reset(20, "t5_reset_idx20");
        for (int i = 0; i < 3; i++) step(20, 1'b1, 1'b0, 1'b0, "t5_after_reset");

        // 6: same-cycle update and lookup of index 7. Clear the pipeline first.
        pulse_reset(7, "t6_reset");
        step(7, 1'b0, 1'b1, 1'b0, "t6_seed");
        step(9, 1'b0, 1'b0, 1'b0, "t6_gap");
        step(7, 1'b0, 1'b0, 1'b0, "t6_same_cycle_old");
        step(7, 1'b0, 1'b0, 1'b0, "t6_next_cycle_new");

        // Random traffic over a small index range, so that updates collide with lookups.
        for (int i = 0; i < 400; i++) begin
            step(int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom), "rand");
        end
        pulse_reset(3, "rand_reset");
        for (int i = 0; i < 100; i++) begin
            step(int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom), "rand2");
        end

`ifdef CHOICE_PRED_STATS_EN
        checks++;
        assert (stat_gp_wins === 32'(gp_wins))
        else begin
            failures++;
            $error("FAIL stat_gp_wins observed=%0d expected=%0d", stat_gp_wins, gp_wins);
        end
        checks++;
        assert (stat_lp_wins === 32'(lp_wins))
        else begin
            failures++;
            $error("FAIL stat_lp_wins observed=%0d expected=%0d", stat_lp_wins, lp_wins);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
